// File: rtl/board_sched.sv
// Snake board bitmap with a combinational renderer port and a vblank-committed write queue.
// Define BOARD_SCHED_WRAP_EN to wrap out-of-range command coordinates instead of flagging err.
module board_sched #(
  parameter int unsigned BW     = 36,
  parameter int unsigned BH     = 18,
  parameter int unsigned QDEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vblank,
  input  logic [5:0] vga_x,
  input  logic [4:0] vga_y,
  output logic       vga_dot,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [5:0] cmd_x,
  input  logic [4:0] cmd_y,
  output logic       rd_valid,
  output logic       rd_data,
  output logic       err,
  output logic       busy
);

  localparam int unsigned NCELL = BW * BH;
  localparam int unsigned PW    = $clog2(QDEPTH);
  localparam int unsigned CW    = PW + 1;
  localparam logic [9:0]  LAST  = 10'(NCELL - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state, state_nx;
  logic [NCELL-1:0] board;
  logic [9:0]       q_idx [QDEPTH];
  logic             q_val [QDEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, slot;
  logic [CW-1:0]    count, count_nx;
  logic [9:0]       clr_idx;
  logic             ready_en;

  logic [9:0] vga_idx, cmd_idx;
  logic [5:0] cx;
  logic [4:0] cy;
  logic       oor, accept, push, pop, clr_cmd, fwd_hit, fwd_val;

  assign vga_idx = 10'(vga_y) * 10'(BW) + 10'(vga_x);
  assign vga_dot = (32'(vga_x) < BW && 32'(vga_y) < BH) ? board[vga_idx] : 1'b0;

`ifdef BOARD_SCHED_WRAP_EN
  assign cx  = (32'(cmd_x) >= BW) ? cmd_x - 6'(BW) : cmd_x;
  assign cy  = (32'(cmd_y) >= BH) ? cmd_y - 5'(BH) : cmd_y;
  assign oor = 1'b0;
`else
  assign cx  = cmd_x;
  assign cy  = cmd_y;
  assign oor = (32'(cmd_x) >= BW || 32'(cmd_y) >= BH) && cmd_op != 2'b11;
`endif

  assign cmd_idx   = 10'(cy) * 10'(BW) + 10'(cx);
  assign cmd_ready = ready_en && state == IDLE && count != CW'(QDEPTH);
  assign accept    = cmd_valid && cmd_ready;
  assign push      = accept && (cmd_op == 2'b01 || cmd_op == 2'b10) && !oor;
  assign clr_cmd   = accept && cmd_op == 2'b11;
  assign pop       = state == IDLE && vblank && count != '0 && !clr_cmd;

  // Scan oldest to newest so the last match is the newest pending write.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_val = 1'b0;
    slot    = '0;
    for (int unsigned i = 0; i < QDEPTH; i++) begin
      slot = rd_ptr + PW'(i);
      if (CW'(i) < count && q_idx[slot] == cmd_idx) begin
        fwd_hit = 1'b1;
        fwd_val = q_val[slot];
      end
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count + CW'(push) - CW'(pop);
    if (clr_cmd) count_nx = '0;
    case (state)
      IDLE:    if (clr_cmd) state_nx = CLEAR;
      CLEAR:   if (vblank && clr_idx == LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_idx[wr_ptr] <= cmd_idx;
      q_val[wr_ptr] <= (cmd_op == 2'b01);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      board    <= '0;
      state    <= IDLE;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      clr_idx  <= '0;
      ready_en <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      state    <= state_nx;
      count    <= count_nx;
      busy     <= (count_nx != '0) || (state_nx == CLEAR);
      rd_valid <= accept && cmd_op == 2'b00;
      rd_data  <= (accept && cmd_op == 2'b00 && !oor) ?
                  (fwd_hit ? fwd_val : board[cmd_idx]) : 1'b0;
      err      <= accept && oor;
      if (clr_cmd) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) begin
          rd_ptr               <= rd_ptr + 1'b1;
          board[q_idx[rd_ptr]] <= q_val[rd_ptr];
        end
      end
      if (state == CLEAR && vblank) begin
        board[clr_idx] <= 1'b0;
        clr_idx        <= (clr_idx == LAST) ? '0 : clr_idx + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_board_sched.sv
// Directed and randomized checks of board_sched against a cell-array/queue reference model.
module tb_board_sched;

  localparam int BWT = 36;
  localparam int BHT = 18;
  localparam int QD  = 4;
  localparam int NC  = BWT * BHT;
`ifdef BOARD_SCHED_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vblank = 1'b0;
  logic [5:0] vga_x = '0;
  logic [4:0] vga_y = '0;
  logic       vga_dot;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [5:0] cmd_x = '0;
  logic [4:0] cmd_y = '0;
  logic       rd_valid, rd_data, err, busy;

  board_sched #(.BW(BWT), .BH(BHT), .QDEPTH(QD)) dut (
    .clk(clk), .rst_n(rst_n), .vblank(vblank),
    .vga_x(vga_x), .vga_y(vga_y), .vga_dot(vga_dot),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y),
    .rd_valid(rd_valid), .rd_data(rd_data), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int idx; bit val;} wr_t;

  bit  m_cells [NC];
  wr_t m_q [$];
  bit  m_clearing;
  int  m_pos;
  bit  m_up;
  bit  e_rdv, e_rdd, e_err;
  int  tests = 0;
  int  fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    return m_up && !m_clearing && (m_q.size() < QD);
  endfunction

  task automatic model_reset();
    foreach (m_cells[i]) m_cells[i] = 1'b0;
    m_q.delete();
    m_clearing = 1'b0;
    m_pos = 0;
    m_up = 1'b0;
    e_rdv = 1'b0; e_rdd = 1'b0; e_err = 1'b0;
  endtask

  // Effect of the coming clock edge given the inputs currently applied.
  task automatic model_edge();
    bit acc, bad, do_pop, do_push, nv;
    int x, y, idx;
    acc = cmd_valid && m_ready();
    e_rdv = 1'b0; e_rdd = 1'b0; e_err = 1'b0;
    do_push = 1'b0; nv = 1'b0; idx = 0;
    if (acc) begin
      x = int'(cmd_x);
      y = int'(cmd_y);
      if (WRAP) begin
        if (x >= BWT) x -= BWT;
        if (y >= BHT) y -= BHT;
        bad = 1'b0;
      end else begin
        bad = (x >= BWT || y >= BHT) && cmd_op != 2'b11;
      end
      idx = y * BWT + x;
      e_err = bad;
      if (cmd_op == 2'b00) begin
        e_rdv = 1'b1;
        if (!bad) begin
          e_rdd = m_cells[idx];
          foreach (m_q[j]) if (m_q[j].idx == idx) e_rdd = m_q[j].val;
        end
      end else if (cmd_op != 2'b11 && !bad) begin
        do_push = 1'b1;
        nv = (cmd_op == 2'b01);
      end
    end
    do_pop = !m_clearing && vblank && m_q.size() > 0 && !(acc && cmd_op == 2'b11);
    if (do_pop) begin
      m_cells[m_q[0].idx] = m_q[0].val;
      void'(m_q.pop_front());
    end
    if (do_push) m_q.push_back('{idx: idx, val: nv});
    if (m_clearing && vblank) begin
      m_cells[m_pos] = 1'b0;
      m_pos++;
      if (m_pos == NC) begin
        m_clearing = 1'b0;
        m_pos = 0;
      end
    end
    if (acc && cmd_op == 2'b11) begin
      m_q.delete();
      m_clearing = 1'b1;
      m_pos = 0;
    end
    m_up = 1'b1;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("rd_valid", rd_valid, e_rdv);
    check("rd_data", rd_data, e_rdd);
    check("err", err, e_err);
    check("busy", busy, (m_q.size() != 0) || m_clearing);
    check("cmd_ready", cmd_ready, m_ready());
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic issue(input logic [1:0] op, input int x, input int y);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_x = 6'(x);
    cmd_y = 5'(y);
  endtask

  task automatic idle_cmd();
    cmd_valid = 1'b0;
  endtask

  task automatic look(input int x, input int y);
    vga_x = 6'(x);
    vga_y = 5'(y);
    #1;
  endtask

  task automatic scan_board();
    for (int y = 0; y < BHT; y++)
      for (int x = 0; x < BWT; x++) begin
        vga_x = 6'(x);
        vga_y = 5'(y);
        tick();
        check("vga_scan", vga_dot, m_cells[y * BWT + x]);
      end
  endtask

  // Called at edge+1; asserts reset between edges and releases at the falling edge.
  task automatic do_reset();
    idle_cmd();
    vblank = 1'b0;
    rst_n = 1'b0;
    look(5, 3);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_data", rd_data, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_vga", vga_dot, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    model_reset();
    #12;
    do_reset();
    check("init_ready", cmd_ready, 1'b1);
    check("init_busy", busy, 1'b0);
    scan_board();
    look(40, 3);
    check("vga_oob_x", vga_dot, 1'b0);

    // Set then forwarded read, commit in vblank.
    issue(2'b01, 5, 3); tick();
    issue(2'b00, 5, 3); tick();
    check("fwd_rd_valid", rd_valid, 1'b1);
    check("fwd_rd_data", rd_data, 1'b1);
    idle_cmd();
    look(5, 3);
    check("vga_uncommitted", vga_dot, 1'b0);
    vblank = 1'b1; tick(); vblank = 1'b0;
    look(5, 3);
    check("vga_committed", vga_dot, 1'b1);
    check("busy_drained", busy, 1'b0);

    // Queue full backpressure.
    for (int k = 0; k < 4; k++) begin
      issue(2'b01, k, 10); tick();
    end
    check("full_ready", cmd_ready, 1'b0);
    issue(2'b01, 4, 10); tick();
    check("full_hold", cmd_ready, 1'b0);
    vblank = 1'b1; tick(); vblank = 1'b0;
    look(0, 10);
    check("one_drained_vga", vga_dot, 1'b1);
    check("ready_after_pop", cmd_ready, 1'b1);
    tick();
    idle_cmd();
    check("fifth_refill", cmd_ready, 1'b0);
    vblank = 1'b1; ticks(4); vblank = 1'b0;
    check("queue_empty", busy, 1'b0);

    // Clear board with pending writes, paused by vblank.
    issue(2'b01, 7, 7); tick();
    issue(2'b01, 8, 8); tick();
    idle_cmd(); vblank = 1'b1; ticks(2); vblank = 1'b0;
    issue(2'b01, 9, 9); tick();
    issue(2'b10, 7, 7); tick();
    issue(2'b11, 50, 30); tick();
    idle_cmd();
    check("clr_busy", busy, 1'b1);
    check("clr_ready", cmd_ready, 1'b0);
    vblank = 1'b1; ticks(300); vblank = 1'b0;
    ticks(30);
    look(0, 10);
    check("clr_paused_busy", busy, 1'b1);
    check("clr_paused_cell", vga_dot, 1'b1);
    vblank = 1'b1; ticks(348); vblank = 1'b0;
    look(0, 10);
    check("clr_done_busy", busy, 1'b0);
    check("clr_done_ready", cmd_ready, 1'b1);
    check("clr_done_cell", vga_dot, 1'b0);
    scan_board();

    // Out-of-range coordinates.
    issue(2'b01, 40, 2); tick();
    check("oor_set_err", err, !WRAP);
    issue(2'b00, 40, 2); tick();
    idle_cmd();
    check("oor_rd_valid", rd_valid, 1'b1);
    check("oor_rd_err", err, !WRAP);
    check("oor_rd_data", rd_data, WRAP);
    tick();
    check("oor_err_clears", err, 1'b0);
    vblank = 1'b1; ticks(2); vblank = 1'b0;
    look(4, 2);
    check("oor_vga", vga_dot, WRAP);

    // Reset mid-drain.
    issue(2'b01, 1, 1); tick();
    issue(2'b01, 2, 1); tick();
    issue(2'b01, 3, 1); tick();
    idle_cmd(); vblank = 1'b1; tick();
    do_reset();
    check("rst_drain_busy", busy, 1'b0);
    vblank = 1'b1; ticks(3); vblank = 1'b0;
    look(3, 1);
    check("rst_drain_lost", vga_dot, 1'b0);

    // Reset mid-clear.
    issue(2'b01, 20, 17); tick();
    idle_cmd(); vblank = 1'b1; tick(); vblank = 1'b0;
    issue(2'b11, 0, 0); tick();
    idle_cmd(); vblank = 1'b1; ticks(100);
    do_reset();
    check("rst_clr_ready", cmd_ready, 1'b1);
    scan_board();

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_op = ($urandom_range(0, 299) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      cmd_x = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(36, 63)) : 6'($urandom_range(0, 35));
      cmd_y = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(18, 31)) : 5'($urandom_range(0, 17));
      if ($urandom_range(0, 9) == 0) vblank = ~vblank;
      vga_x = 6'($urandom_range(0, 35));
      vga_y = 5'($urandom_range(0, 17));
      tick();
      check("rand_vga", vga_dot, m_cells[int'(vga_y) * BWT + int'(vga_x)]);
    end
    idle_cmd();
    vblank = 1'b1; ticks(700); vblank = 1'b0;
    scan_board();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
